// File: rtl/search_row_shifter.sv
// Search-row shifter: loads a 23-pixel window and emits eight overlapping
// 16-pixel candidates, one per accepted cycle, with back-to-back row reload.
module search_row_shifter #(
  parameter int DATA_W = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 load_i,
  input  logic [16*DATA_W-1:0] row_i,
  input  logic [7*DATA_W-1:0]  left_i,
  input  logic                 stall_i,
  output logic                 load_ready_o,
  output logic [16*DATA_W-1:0] cand_o,
  output logic [2:0]           pos_o,
  output logic                 cand_valid_o,
  output logic                 done_o,
  output logic [7:0]           blk_cnt_o
);

  localparam int WIN_W  = 23 * DATA_W;
  localparam int CAND_W = 16 * DATA_W;

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  state_t             state, state_nxt;
  logic [WIN_W-1:0]   window;
  logic [2:0]         pos;
  logic               done;
  logic [7:0]         blk_cnt;

  logic               cand_acc;
  logic               last_acc;
  logic               load_acc;
  logic               load_ready;

  // Drop the lowest pixel and zero-fill the top so candidate p starts at pixel p.
  function automatic logic [WIN_W-1:0] shift_window(input logic [WIN_W-1:0] w);
    return {{DATA_W{1'b0}}, w[WIN_W-1:DATA_W]};
  endfunction

  assign cand_acc = (state == SHIFT) && !stall_i;
  assign last_acc = cand_acc && (pos == 3'd7);
  assign load_acc = load_i && load_ready;

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (load_acc) state_nxt = SHIFT;
      end
      SHIFT: begin
        if (last_acc) state_nxt = load_acc ? SHIFT : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    load_ready   = 1'b0;
    cand_valid_o = 1'b0;
    case (state)
      IDLE:  load_ready = 1'b1;
      SHIFT: begin
        cand_valid_o = 1'b1;
        load_ready   = (pos == 3'd7) && !stall_i;
      end
      default: ;
    endcase
  end

  // Window and position datapath; a load takes priority over the final shift
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      window <= '0;
      pos    <= '0;
    end else if (load_acc) begin
      window <= {left_i, row_i};
      pos    <= 3'd0;
    end else if (cand_acc) begin
      window <= shift_window(window);
      pos    <= pos + 3'd1;
    end
  end

  // Row completion: done pulse and wrapping row counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      done    <= 1'b0;
      blk_cnt <= 8'd0;
    end else begin
      done <= last_acc;
      if (last_acc) blk_cnt <= blk_cnt + 8'd1;
    end
  end

  assign load_ready_o = load_ready;
  assign cand_o       = window[CAND_W-1:0];
  assign pos_o        = pos;
  assign done_o       = done;
  assign blk_cnt_o    = blk_cnt;

endmodule
